// File: rtl/otter_intrpt_ctrl_if.sv
// Interrupt handshake and MMIO register bus between the CU/data bus (master)
// and the interrupt controller (slave).
interface otter_intrpt_ctrl_if;
  logic        intrpt_vld;
  logic        intrpt_taken;
  logic [1:0]  mmio_addr;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (
    input  intrpt_vld,
    input  mmio_rdata,
    output intrpt_taken,
    output mmio_addr,
    output mmio_wr,
    output mmio_rd,
    output mmio_wdata
  );

  modport slave (
    output intrpt_vld,
    output mmio_rdata,
    input  intrpt_taken,
    input  mmio_addr,
    input  mmio_wr,
    input  mmio_rd,
    input  mmio_wdata
  );
endinterface

// File: rtl/otter_intrpt_ctrl.sv
// Memory-mapped interrupt controller: synchronizes and edge-latches sources,
// raises one level request to the CU and tracks the serviced source.
module otter_intrpt_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  otter_intrpt_ctrl_if.slave bus
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_nxt;

  logic [NUM_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]  edge_q;
  logic [NUM_SRC-1:0]  enable_q;
  logic [NUM_SRC-1:0]  pending_q;
  logic                cause_active_q;
  logic [ID_W-1:0]     cause_id_q;
  logic                intrpt_vld_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_SRC-1:0]  rise_c;
  logic [NUM_SRC-1:0]  req_c;
  logic [NUM_SRC-1:0]  sel_oh_c;
  logic [ID_W-1:0]     sel_id_c;
  logic [NUM_SRC-1:0]  pending_nxt_c;
  logic [DATA_W-1:0]   rd_mux_c;
  logic                take_c;
  logic                eoi_c;
  logic                wr_enable_c;
  logic                wr_pending_c;
  logic                wr_eoi_c;
  logic                unused_wdata;

  assign unused_wdata = ^bus.mmio_wdata;

  assign wr_enable_c  = bus.mmio_wr && (bus.mmio_addr == ADDR_ENABLE);
  assign wr_pending_c = bus.mmio_wr && (bus.mmio_addr == ADDR_PENDING);
  assign wr_eoi_c     = bus.mmio_wr && (bus.mmio_addr == ADDR_EOI);

  // Edge detect on the synchronized line against its previous value
  assign rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign req_c  = pending_q & enable_q;

  // Lowest set bit of the request vector wins
  assign sel_oh_c = req_c & (~req_c + NUM_SRC'(1));

  always_comb begin
    sel_id_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_c[i]) sel_id_c = ID_W'(i);
    end
  end

  // FSM next state plus capture/end-of-service strobes
  always_comb begin
    state_nxt = state_q;
    take_c    = 1'b0;
    eoi_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_c) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.intrpt_taken && (|req_c)) begin
          take_c    = 1'b1;
          state_nxt = ST_SERVICE;
        end else if (!(|req_c)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi_c) begin
          eoi_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clears apply first so a same-cycle edge always leaves the bit set
  always_comb begin
    pending_nxt_c = pending_q;
    if (wr_pending_c) pending_nxt_c = pending_nxt_c & ~bus.mmio_wdata[NUM_SRC-1:0];
    if (take_c)       pending_nxt_c = pending_nxt_c & ~sel_oh_c;
    pending_nxt_c = pending_nxt_c | rise_c;
  end

  always_comb begin
    rd_mux_c = '0;
    case (bus.mmio_addr)
      ADDR_ENABLE:  rd_mux_c = DATA_W'(enable_q);
      ADDR_PENDING: rd_mux_c = DATA_W'(pending_q);
      ADDR_CAUSE:   rd_mux_c = {cause_active_q, 26'd0, cause_id_q};
      ADDR_EOI:     rd_mux_c = '0;
      default:      rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      edge_q         <= '0;
      enable_q       <= '0;
      pending_q      <= '0;
      cause_active_q <= 1'b0;
      cause_id_q     <= '0;
      intrpt_vld_q   <= 1'b0;
      rdata_q        <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      edge_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_nxt_c;
      if (wr_enable_c) enable_q <= bus.mmio_wdata[NUM_SRC-1:0];
      if (take_c) begin
        cause_active_q <= 1'b1;
        cause_id_q     <= sel_id_c;
      end else if (eoi_c) begin
        cause_active_q <= 1'b0;
      end
      // Registered from next state so the request drops for a full cycle between services
      intrpt_vld_q <= (state_nxt == ST_REQ);
      if (bus.mmio_rd) rdata_q <= rd_mux_c;
    end
  end

  assign bus.intrpt_vld = intrpt_vld_q;
  assign bus.mmio_rdata = rdata_q;

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// Directed bench for otter_intrpt_ctrl: reset, single source, priority,
// withdrawal, same-cycle collisions and reset during service.
module tb_otter_intrpt_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_src;
  int         total;
  int         bad;

  otter_intrpt_ctrl_if bus ();

  otter_intrpt_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_src(irq_src),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mmio_write(input logic [1:0] addr, input logic [31:0] data);
    bus.mmio_addr  = addr;
    bus.mmio_wdata = data;
    bus.mmio_wr    = 1'b1;
    @(negedge clk);
    bus.mmio_wr    = 1'b0;
  endtask

  task automatic mmio_read(input logic [1:0] addr, output logic [31:0] data);
    bus.mmio_addr = addr;
    bus.mmio_rd   = 1'b1;
    @(negedge clk);
    bus.mmio_rd   = 1'b0;
    data = bus.mmio_rdata;
  endtask

  task automatic pulse_taken();
    bus.intrpt_taken = 1'b1;
    @(negedge clk);
    bus.intrpt_taken = 1'b0;
  endtask

  task automatic wait_vld(input int budget, output bit ok);
    ok = bus.intrpt_vld;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = bus.intrpt_vld;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    irq_src = 8'hFF;
    repeat (2) @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", bus.intrpt_vld); end
    total++; if (bus.mmio_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.mmio_rdata); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL reset_pending got=%h exp=000000ff", d); end
    mmio_read(2'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_enable got=%h exp=0", d); end
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL idle_vld got=%b exp=0", bus.intrpt_vld); end
    irq_src = 8'h00;
    mmio_write(2'd1, 32'hFFFF_FFFF);
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_all got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    mmio_write(2'd0, 32'h0000_00C3);
    bus.mmio_addr  = 2'd0;
    bus.mmio_wdata = 32'hFFFF_FF5A;
    bus.mmio_wr    = 1'b1;
    bus.mmio_rd    = 1'b1;
    @(negedge clk);
    bus.mmio_wr    = 1'b0;
    bus.mmio_rd    = 1'b0;
    total++; if (bus.mmio_rdata !== 32'h0000_00C3) begin bad++; $display("FAIL rw_same_cycle got=%h exp=000000c3", bus.mmio_rdata); end
    mmio_read(2'd0, d);
    total++; if (d !== 32'h0000_005A) begin bad++; $display("FAIL enable_mask got=%h exp=0000005a", d); end
    mmio_write(2'd2, 32'hFFFF_FFFF);
    mmio_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cause_ro got=%h exp=0", d); end
    mmio_read(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL eoi_read got=%h exp=0", d); end
    repeat (2) @(negedge clk);
    total++; if (bus.mmio_rdata !== 32'h0) begin bad++; $display("FAIL rdata_hold got=%h exp=0", bus.mmio_rdata); end
    mmio_write(2'd0, 32'h0);
  endtask

  task automatic test_single();
    logic [31:0] d;
    mmio_write(2'd0, 32'h0000_0004);
    irq_src = 8'h04;
    repeat (3) @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", bus.intrpt_vld); end
    @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", bus.intrpt_vld); end
    pulse_taken();
    irq_src = 8'h00;
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL single_vld_drop got=%b exp=0", bus.intrpt_vld); end
    mmio_read(2'd2, d);
    total++; if (d !== 32'h8000_0002) begin bad++; $display("FAIL single_cause got=%h exp=80000002", d); end
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL single_pending got=%h exp=0", d); end
    mmio_write(2'd3, 32'h1234_5678);
    mmio_read(2'd2, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL single_eoi got=%h exp=00000002", d); end
    repeat (2) @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.intrpt_vld); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bit ok;
    mmio_write(2'd0, 32'h0000_00FF);
    irq_src = 8'h22;
    wait_vld(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_first_timeout got=0 exp=1"); end
    pulse_taken();
    mmio_read(2'd2, d);
    total++; if (d !== 32'h8000_0001) begin bad++; $display("FAIL prio_first got=%h exp=80000001", d); end
    mmio_write(2'd3, 32'h0);
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL prio_gap got=%b exp=0", bus.intrpt_vld); end
    @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b1) begin bad++; $display("FAIL prio_second_req got=%b exp=1", bus.intrpt_vld); end
    pulse_taken();
    mmio_read(2'd2, d);
    total++; if (d !== 32'h8000_0005) begin bad++; $display("FAIL prio_second got=%h exp=80000005", d); end
    mmio_write(2'd3, 32'h0);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    bit ok;
    irq_src = 8'h01;
    wait_vld(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL wd_timeout got=0 exp=1"); end
    mmio_write(2'd1, 32'h0000_0001);
    total++; if (bus.intrpt_vld !== 1'b1) begin bad++; $display("FAIL wd_still_req got=%b exp=1", bus.intrpt_vld); end
    @(negedge clk);
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL wd_drop got=%b exp=0", bus.intrpt_vld); end
    pulse_taken();
    mmio_read(2'd2, d);
    total++; if (d !== 32'h0000_0005) begin bad++; $display("FAIL wd_cause got=%h exp=00000005", d); end
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL wd_ignored got=%b exp=0", bus.intrpt_vld); end
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bit ok;
    // Edge arrival and W1C in the same cycle
    mmio_write(2'd0, 32'h0);
    irq_src = 8'h01;
    repeat (2) @(negedge clk);
    mmio_write(2'd1, 32'h0000_0001);
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL coll_w1c got=%h exp=00000001", d); end
    irq_src = 8'h00;
    repeat (3) @(negedge clk);
    // Edge arrival and taken-clear in the same cycle
    mmio_write(2'd0, 32'h0000_0001);
    wait_vld(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_req_timeout got=0 exp=1"); end
    irq_src = 8'h01;
    repeat (2) @(negedge clk);
    pulse_taken();
    mmio_read(2'd2, d);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL coll_taken_cause got=%h exp=80000000", d); end
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL coll_taken_pending got=%h exp=00000001", d); end
    mmio_write(2'd3, 32'h0);
    wait_vld(4, ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_rerequest got=0 exp=1"); end
    pulse_taken();
    mmio_write(2'd3, 32'h0);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_service();
    logic [31:0] d;
    bit ok;
    mmio_write(2'd0, 32'h0000_00FF);
    irq_src = 8'h31;
    wait_vld(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL rms_timeout got=0 exp=1"); end
    pulse_taken();
    irq_src = 8'h00;
    repeat (3) @(negedge clk);
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0000_0030) begin bad++; $display("FAIL rms_pre_pending got=%h exp=00000030", d); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.intrpt_vld !== 1'b0) begin bad++; $display("FAIL rms_vld got=%b exp=0", bus.intrpt_vld); end
    total++; if (bus.mmio_rdata !== 32'h0) begin bad++; $display("FAIL rms_rdata got=%h exp=0", bus.mmio_rdata); end
    mmio_read(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rms_cause got=%h exp=0", d); end
    mmio_read(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rms_pending got=%h exp=0", d); end
    mmio_read(2'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rms_enable got=%h exp=0", d); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n            = 1'b0;
    irq_src          = 8'h00;
    bus.intrpt_taken = 1'b0;
    bus.mmio_addr    = 2'd0;
    bus.mmio_wr      = 1'b0;
    bus.mmio_rd      = 1'b0;
    bus.mmio_wdata   = 32'h0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_single();
    test_priority();
    test_withdraw();
    test_collision();
    test_reset_mid_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
